// File: rtl/sca_trigger_pkg.sv
// sca_trigger_pkg: shared types and constants for the side-channel capture
// trigger sequencer.
//   sca_trig_state_e : sequencer state encoding
//   MioIdxTrigger    : MIO index whose pad output carries the capture trigger
package sca_trigger_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    DELAY   = 3'd2,
    ACTIVE  = 3'd3,
    HOLDOFF = 3'd4
  } sca_trig_state_e;

  localparam int MioIdxTrigger = 15;

endpackage

// File: rtl/sca_trigger_ctrl.sv
// sca_trigger_ctrl: capture-trigger sequencer. It arms on the software
// trigger, waits for the AES to go busy, waits cfg_delay_i cycles, then drives
// a trigger pulse of cfg_width_i cycles (or one that follows AES busy when the
// width is 0). It issues one capture per software trigger assertion.
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   cfg_en_i        block enable; low forces IDLE
//   cfg_delay_i     busy-detect to trigger delay, in cycles
//   cfg_width_i     trigger high time in cycles; 0 = track AES busy
//   sw_trig_i       software capture request (level)
//   aes_idle_i      AES idle status
//   clr_i           clears capture_cnt_o and miss_o
//   trig_o          registered trigger to pad
//   busy_o          sequencer is not IDLE
//   capture_cnt_o   saturating count of trigger pulses
//   miss_o          sticky: AES went idle before the trigger fired
module sca_trigger_ctrl
  import sca_trigger_pkg::*;
#(
  parameter int DelayW = 16,
  parameter int WidthW = 16,
  parameter int CntW   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cfg_en_i,
  input  logic [DelayW-1:0] cfg_delay_i,
  input  logic [WidthW-1:0] cfg_width_i,
  input  logic              sw_trig_i,
  input  logic              aes_idle_i,
  input  logic              clr_i,
  output logic              trig_o,
  output logic              busy_o,
  output logic [CntW-1:0]   capture_cnt_o,
  output logic              miss_o
);

  // One down-counter serves both the delay and the pulse width.
  localparam int CtrW = (DelayW > WidthW) ? DelayW : WidthW;

  sca_trig_state_e   state_q;
  logic [CtrW-1:0]   ctr_q;
  logic [WidthW-1:0] width_q;

  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (v == '1) ? v : v + CntW'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      ctr_q         <= '0;
      width_q       <= '0;
      trig_o        <= 1'b0;
      busy_o        <= 1'b0;
      capture_cnt_o <= '0;
      miss_o        <= 1'b0;
    end else begin
      if (!cfg_en_i) begin
        state_q <= IDLE;
        trig_o  <= 1'b0;
        busy_o  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (sw_trig_i) begin
              state_q <= ARMED;
              busy_o  <= 1'b1;
            end
          end
          ARMED: begin
            if (!sw_trig_i) begin
              state_q <= IDLE;
              busy_o  <= 1'b0;
            end else if (!aes_idle_i) begin
              // Configuration is sampled only here, so changes mid-capture
              // apply to the next capture.
              width_q <= cfg_width_i;
              if (cfg_delay_i == '0) begin
                state_q       <= ACTIVE;
                trig_o        <= 1'b1;
                ctr_q         <= CtrW'(cfg_width_i);
                capture_cnt_o <= sat_inc(capture_cnt_o);
              end else begin
                state_q <= DELAY;
                ctr_q   <= CtrW'(cfg_delay_i);
              end
            end
          end
          DELAY: begin
            // Reaching the end of the delay wins over a same-edge idle.
            if (ctr_q == CtrW'(1)) begin
              state_q       <= ACTIVE;
              trig_o        <= 1'b1;
              ctr_q         <= CtrW'(width_q);
              capture_cnt_o <= sat_inc(capture_cnt_o);
            end else if (aes_idle_i) begin
              state_q <= HOLDOFF;
              ctr_q   <= '0;
              miss_o  <= 1'b1;
            end else begin
              ctr_q <= ctr_q - CtrW'(1);
            end
          end
          ACTIVE: begin
            if (width_q == '0) begin
              if (aes_idle_i) begin
                state_q <= HOLDOFF;
                trig_o  <= 1'b0;
              end
            end else if (ctr_q == CtrW'(1)) begin
              state_q <= HOLDOFF;
              trig_o  <= 1'b0;
              ctr_q   <= '0;
            end else begin
              ctr_q <= ctr_q - CtrW'(1);
            end
          end
          HOLDOFF: begin
            // Wait for the request to drop so a held trigger captures once.
            if (aes_idle_i && !sw_trig_i) begin
              state_q <= IDLE;
              busy_o  <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            trig_o  <= 1'b0;
            busy_o  <= 1'b0;
          end
        endcase
      end
      // Clear overrides any same-edge increment or miss set.
      if (clr_i) begin
        capture_cnt_o <= '0;
        miss_o        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sca_trigger_ctrl.sv
module tb_sca_trigger_ctrl;

  localparam int DelayW = 16;
  localparam int WidthW = 16;
  localparam int CntW   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_en;
  logic [DelayW-1:0] cfg_delay;
  logic [WidthW-1:0] cfg_width;
  logic              sw_trig;
  logic              aes_idle;
  logic              clr;
  logic              trig;
  logic              busy;
  logic [CntW-1:0]   capture_cnt;
  logic              miss;

  sca_trigger_ctrl #(.DelayW(DelayW), .WidthW(WidthW), .CntW(CntW)) dut (
    .clk_i(clk), .rst_i(rst), .cfg_en_i(cfg_en), .cfg_delay_i(cfg_delay),
    .cfg_width_i(cfg_width), .sw_trig_i(sw_trig), .aes_idle_i(aes_idle),
    .clr_i(clr), .trig_o(trig), .busy_o(busy), .capture_cnt_o(capture_cnt),
    .miss_o(miss)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int rise;
    int len;
    int cnt;
  } pulse_t;

  pulse_t exp_q[$];
  int vecs = 0;
  int errs = 0;
  int exp_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: measure each trig pulse and compare against the scoreboard.
  bit prev_trig = 1'b0;
  int p_rise, p_len, p_cnt;
  always @(negedge clk) begin
    if (trig && !prev_trig) begin
      p_rise = cyc;
      p_len  = 0;
      p_cnt  = int'(capture_cnt);
    end
    if (trig) p_len++;
    if (!trig && prev_trig) begin
      if (exp_q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_pulse: rise at cycle %0d len %0d, none expected", p_rise, p_len);
      end else begin
        pulse_t e;
        e = exp_q.pop_front();
        chk("pulse_rise", p_rise, e.rise);
        chk("pulse_len", p_len, e.len);
        chk("pulse_cnt", p_cnt, e.cnt);
      end
    end
    prev_trig = trig;
  end

  // One capture: arm, hold AES busy for b cycles, then return to idle.
  task automatic cap(input int d, input int w, input int b, input bit pulse, input bit drop_sw);
    cfg_delay = DelayW'(d);
    cfg_width = WidthW'(w);
    sw_trig   = 1'b1;
    tick(1);
    aes_idle = 1'b0;
    if (pulse) begin
      pulse_t e;
      exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
      e.rise = cyc + 1 + d;
      e.len  = (w != 0) ? w : b - d;
      e.cnt  = exp_cnt;
      exp_q.push_back(e);
    end
    tick(b);
    aes_idle = 1'b1;
    if (drop_sw) sw_trig = 1'b0;
    tick(2);
  endtask

  initial begin
    rst = 1'b1; cfg_en = 1'b0; cfg_delay = '0; cfg_width = '0;
    sw_trig = 1'b0; aes_idle = 1'b1; clr = 1'b0;
    tick(2);
    chk("rst_trig", int'(trig), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cnt", int'(capture_cnt), 0);
    chk("rst_miss", int'(miss), 0);
    rst = 1'b0; cfg_en = 1'b1;
    tick(2);

    // D=0, W=4; width change during the pulse must not affect it.
    cfg_delay = '0; cfg_width = 16'd4; sw_trig = 1'b1;
    tick(1);
    aes_idle = 1'b0;
    begin
      pulse_t e;
      exp_cnt = 1;
      e.rise = cyc + 1; e.len = 4; e.cnt = 1;
      exp_q.push_back(e);
    end
    tick(1);
    cfg_width = 16'd9;
    tick(2);
    chk("t1_busy_mid", int'(busy), 1);
    tick(17);
    aes_idle = 1'b1; sw_trig = 1'b0;
    tick(2);
    chk("t1_busy_end", int'(busy), 0);
    chk("t1_cnt", int'(capture_cnt), 1);

    // D=10, track-busy mode, AES busy 30 cycles.
    cap(10, 0, 30, 1'b1, 1'b1);
    chk("t2_busy_end", int'(busy), 0);

    // Generic delay + width.
    cap(3, 2, 12, 1'b1, 1'b1);

    // D=50 with a short AES op: miss, no pulse, then clear.
    cap(50, 4, 20, 1'b0, 1'b1);
    chk("t3_miss", int'(miss), 1);
    chk("t3_cnt", int'(capture_cnt), exp_cnt);
    clr = 1'b1; tick(1); clr = 1'b0; exp_cnt = 0;
    tick(1);
    chk("t3_miss_clr", int'(miss), 0);
    chk("t3_cnt_clr", int'(capture_cnt), 0);

    // Held software trigger: one pulse for two AES operations.
    cap(0, 2, 6, 1'b1, 1'b0);
    chk("t4_hold_busy", int'(busy), 1);
    cap(0, 2, 6, 1'b0, 1'b0);
    sw_trig = 1'b0;
    tick(2);
    chk("t4_idle_busy", int'(busy), 0);
    cap(0, 2, 6, 1'b1, 1'b1);
    chk("t4_cnt", int'(capture_cnt), exp_cnt);

    // Enable dropped during DELAY.
    cfg_delay = 16'd20; cfg_width = 16'd3; sw_trig = 1'b1;
    tick(1);
    aes_idle = 1'b0;
    tick(5);
    cfg_en = 1'b0;
    tick(1);
    chk("t5_en_busy", int'(busy), 0);
    chk("t5_en_trig", int'(trig), 0);
    sw_trig = 1'b0; aes_idle = 1'b1; cfg_en = 1'b1;
    tick(3);
    chk("t5_en_cnt", int'(capture_cnt), exp_cnt);

    // Reset during ACTIVE truncates the pulse after 3 cycles.
    cfg_delay = '0; cfg_width = 16'd10; sw_trig = 1'b1;
    tick(1);
    aes_idle = 1'b0;
    begin
      pulse_t e;
      exp_cnt++;
      e.rise = cyc + 1; e.len = 3; e.cnt = exp_cnt;
      exp_q.push_back(e);
    end
    tick(3);
    rst = 1'b1;
    tick(1);
    chk("t5_rst_trig", int'(trig), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_cnt", int'(capture_cnt), 0);
    exp_cnt = 0;
    rst = 1'b0; sw_trig = 1'b0; aes_idle = 1'b1;
    tick(2);

    // Saturation of the 4-bit capture counter.
    for (int i = 0; i < 17; i++) cap(0, 1, 3, 1'b1, 1'b1);
    chk("t6_sat", int'(capture_cnt), 15);

    // Clear on the same edge as a capture increment yields 0.
    cfg_delay = '0; cfg_width = 16'd2; sw_trig = 1'b1;
    tick(1);
    aes_idle = 1'b0; clr = 1'b1;
    begin
      pulse_t e;
      exp_cnt = 0;
      e.rise = cyc + 1; e.len = 2; e.cnt = 0;
      exp_q.push_back(e);
    end
    tick(1);
    clr = 1'b0;
    tick(4);
    aes_idle = 1'b1; sw_trig = 1'b0;
    tick(3);
    chk("t6_clr_cnt", int'(capture_cnt), 0);

    tick(3);
    chk("pending_pulses", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
